// File: rtl/sram_serial_io_ctrl_p.sv
// Serial-to-SRAM bridge: {addr,data} frames arrive LSB first on si_i and are then written to,
// or read back from, a synchronous single-port SRAM. Reads are unloaded serially on so_o.
module sram_serial_io_ctrl_p #(
  parameter int DATA_WIDTH   = 8,
  parameter int ADDR_WIDTH   = 9,
  parameter int READ_LATENCY = 1,
  parameter int AUTO_INC     = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  bgn_i,
  input  logic                  si_i,
  input  logic                  load_n_i,
  input  logic [1:0]            ctrl_i,
  input  logic [DATA_WIDTH-1:0] pi_i,
  output logic                  rdy_o,
  output logic                  d_we_o,
  output logic                  cen_o,
  output logic                  so_o,
  output logic [ADDR_WIDTH-1:0] a_o,
  output logic [DATA_WIDTH-1:0] po_o
);

  localparam int FW = ADDR_WIDTH + DATA_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] INC = (AUTO_INC != 0) ? ADDR_WIDTH'(1) : '0;
  localparam logic [2:0] LAT_M1 = 3'(READ_LATENCY - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SHIFT, S_WR, S_RD, S_RD_WAIT, S_DONE
  } state_t;

  state_t                state_q, state_d;
  logic [1:0]            op_q, op_d;
  logic [FW-1:0]         sr_q, sr_d;
  logic                  so_q, so_d;
  logic [2:0]            cnt_q, cnt_d;
  logic                  rdy_q, cen_q, d_we_q;
  logic [ADDR_WIDTH-1:0] addr_inc;

  assign addr_inc = sr_q[FW-1:DATA_WIDTH] + INC;

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    sr_d    = sr_q;
    so_d    = so_q;
    cnt_d   = cnt_q;
    if (!bgn_i) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (!load_n_i) begin
            op_d = ctrl_i;
            case (ctrl_i)
              2'b10:   state_d = S_RD;
              2'b11:   state_d = S_WR;
              default: state_d = S_SHIFT;
            endcase
          end
        end
        S_SHIFT: begin
          so_d = sr_q[0];
          if (op_q == 2'b00) sr_d = {si_i, sr_q[FW-1:1]};
          else sr_d[DATA_WIDTH-1:0] = {si_i, sr_q[DATA_WIDTH-1:1]};
          state_d = S_DONE;
        end
        S_WR: begin
          sr_d[FW-1:DATA_WIDTH] = addr_inc;
          state_d = S_DONE;
        end
        S_RD: begin
          cnt_d   = LAT_M1;
          state_d = S_RD_WAIT;
        end
        S_RD_WAIT: begin
          // Down-counter: SR is only touched on the terminal edge, so an abort leaves it intact.
          if (cnt_q == 3'd0) begin
            sr_d    = {addr_inc, pi_i};
            state_d = S_DONE;
          end else begin
            cnt_d = cnt_q - 3'd1;
          end
        end
        S_DONE: begin
          if (load_n_i) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Strobes are registered from the next state so the SRAM pins never glitch.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      op_q    <= 2'b00;
      sr_q    <= '0;
      so_q    <= 1'b0;
      cnt_q   <= 3'd0;
      rdy_q   <= 1'b0;
      cen_q   <= 1'b1;
      d_we_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      sr_q    <= sr_d;
      so_q    <= so_d;
      cnt_q   <= cnt_d;
      rdy_q   <= (state_d == S_DONE);
      cen_q   <= !((state_d == S_WR) || (state_d == S_RD));
      d_we_q  <= !(state_d == S_WR);
    end
  end

  assign rdy_o  = rdy_q;
  assign cen_o  = cen_q;
  assign d_we_o = d_we_q;
  assign so_o   = so_q;
  assign a_o    = sr_q[FW-1:DATA_WIDTH];
  assign po_o   = sr_q[DATA_WIDTH-1:0];

endmodule
